// File: rtl/aux_pkg.sv
// Shared types for the input-conditioning blocks.
//   debounce_state_t : qualification FSM state of debounce_filter
package aux_pkg;

  typedef enum logic {
    ST_STABLE,
    ST_QUALIFY
  } debounce_state_t;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous bit.
// Ports:
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset, every stage loads RESET_VALUE
//   i_data  : asynchronous input
//   o_data  : synchronised output (last stage)
module sync_chain #(
  parameter int unsigned STAGES      = 2,
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_data,
  output logic o_data
);

  logic [STAGES-1:0] stages_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stages_q <= {STAGES{RESET_VALUE}};
    end else begin
      stages_q <= {stages_q[STAGES-2:0], i_data};
    end
  end

  assign o_data = stages_q[STAGES-1];

endmodule

// File: rtl/debounce_filter.sv
// Debounces an asynchronous single-bit input: synchronises it, then accepts a
// new level only after DEBOUNCE_CYCLES consecutive synchronised samples of it.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   i_data  : raw asynchronous input, may glitch
//   o_data  : debounced level (registered, resets to RESET_VALUE)
//   o_rise  : one-cycle pulse on an accepted 0->1 transition (registered)
//   o_fall  : one-cycle pulse on an accepted 1->0 transition (registered)
//   o_busy  : high while a candidate level is being qualified
module debounce_filter #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter logic        RESET_VALUE     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_data,
  output logic o_data,
  output logic o_rise,
  output logic o_fall,
  output logic o_busy
);

  import aux_pkg::*;

  localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  // Counter value on the edge before acceptance: cnt+1 == DEBOUNCE_CYCLES.
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : gen_bad_sync_stages
    $fatal(1, "debounce_filter: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : gen_bad_debounce_cycles
    $fatal(1, "debounce_filter: DEBOUNCE_CYCLES must be >= 1");
  end

  logic            sync;
  debounce_state_t state_q;
  logic [CntW-1:0] cnt_q;
  logic            data_q;
  logic            rise_q;
  logic            fall_q;

  sync_chain #(
    .STAGES     (SYNC_STAGES),
    .RESET_VALUE(RESET_VALUE)
  ) u_sync_chain (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_data (i_data),
    .o_data (sync)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      data_q  <= RESET_VALUE;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        ST_STABLE: begin
          if (sync != data_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              // Single-sample qualification: accept on the first differing edge.
              data_q <= sync;
              rise_q <= sync;
              fall_q <= ~sync;
            end else begin
              cnt_q   <= CntW'(1);
              state_q <= ST_QUALIFY;
            end
          end
        end
        ST_QUALIFY: begin
          if (sync == data_q) begin
            // Returned to the current level: discard the candidate.
            cnt_q   <= '0;
            state_q <= ST_STABLE;
          end else if (cnt_q == CntLast) begin
            data_q  <= sync;
            rise_q  <= sync;
            fall_q  <= ~sync;
            cnt_q   <= '0;
            state_q <= ST_STABLE;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_STABLE;
        end
      endcase
    end
  end

  assign o_data = data_q;
  assign o_rise = rise_q;
  assign o_fall = fall_q;
  assign o_busy = (state_q == ST_QUALIFY);

endmodule

// File: tb/tb_debounce_filter.sv
// Scoreboard bench for debounce_filter. Stimulus pushes the expected pulse
// (edge number, direction) into a per-DUT queue; a monitor pops and compares
// whenever a DUT raises o_rise or o_fall.
//   dut_a : SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_VALUE=0
//   dut_b : SYNC_STAGES=2, DEBOUNCE_CYCLES=1, RESET_VALUE=1
module tb_debounce_filter;

  typedef struct packed {
    logic [31:0] edge_no;
    logic        rise;
  } exp_t;

  logic clk;
  logic rst_n;
  logic din_a, din_b;
  logic data_a, rise_a, fall_a, busy_a;
  logic data_b, rise_b, fall_b, busy_b;

  int unsigned edge_n = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        qa[$];
  exp_t        qb[$];

  debounce_filter #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .RESET_VALUE    (1'b0)
  ) dut_a (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_data (din_a),
    .o_data (data_a),
    .o_rise (rise_a),
    .o_fall (fall_a),
    .o_busy (busy_a)
  );

  debounce_filter #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(1),
    .RESET_VALUE    (1'b1)
  ) dut_b (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_data (din_b),
    .o_data (data_b),
    .o_rise (rise_b),
    .o_fall (fall_b),
    .o_busy (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, req, edge_n);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitors: every pulse must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (rise_a || fall_a) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_pulse actual rise=%0b fall=%0b required none (edge %0d)",
                 rise_a, fall_a, edge_n);
      end else begin
        e = qa.pop_front();
        check("a_pulse_edge", edge_n, e.edge_no);
        check("a_pulse_rise", {31'd0, rise_a}, {31'd0, e.rise});
        check("a_pulse_fall", {31'd0, fall_a}, {31'd0, ~e.rise});
        check("a_pulse_level", {31'd0, data_a}, {31'd0, e.rise});
      end
    end
    if (rise_b || fall_b) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_pulse actual rise=%0b fall=%0b required none (edge %0d)",
                 rise_b, fall_b, edge_n);
      end else begin
        e = qb.pop_front();
        check("b_pulse_edge", edge_n, e.edge_no);
        check("b_pulse_rise", {31'd0, rise_b}, {31'd0, e.rise});
        check("b_pulse_fall", {31'd0, fall_b}, {31'd0, ~e.rise});
        check("b_pulse_level", {31'd0, data_b}, {31'd0, e.rise});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bounce [6];
    int unsigned e0;
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset state.
    rst_n = 1'b0;
    din_a = 1'b0;
    din_b = 1'b1;
    tick(3);
    check("rst_a_data", {31'd0, data_a}, 32'd0);
    check("rst_a_busy", {31'd0, busy_a}, 32'd0);
    check("rst_a_pulses", {30'd0, rise_a, fall_a}, 32'd0);
    check("rst_b_data", {31'd0, data_b}, 32'd1);
    check("rst_b_busy", {31'd0, busy_b}, 32'd0);
    rst_n = 1'b1;
    tick(5);

    // Clean rise: accepted at edge 6, busy after edges 3..5.
    din_a = 1'b1;
    e0 = edge_n;
    qa.push_back('{edge_no: e0 + 6, rise: 1'b1});
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("rise_busy_k%0d", k), {31'd0, busy_a}, {31'd0, (k >= 3 && k <= 5)});
      check($sformatf("rise_data_k%0d", k), {31'd0, data_a}, {31'd0, (k >= 6)});
    end

    // Fall after 6 edges.
    din_a = 1'b0;
    e0 = edge_n;
    qa.push_back('{edge_no: e0 + 6, rise: 1'b0});
    tick(8);
    check("fall_data", {31'd0, data_a}, 32'd0);

    // Bounce then settle: only the final hold qualifies.
    for (int i = 0; i < 6; i++) begin
      din_a = bounce[i];
      if (i == 5) begin
        e0 = edge_n;
        qa.push_back('{edge_no: e0 + 6, rise: 1'b1});
      end
      @(negedge clk);
    end
    tick(7);
    check("bounce_data", {31'd0, data_a}, 32'd1);
    check("bounce_busy", {31'd0, busy_a}, 32'd0);

    // Alternation every 10 cycles: 0,1,0,1,0.
    for (int n = 0; n < 5; n++) begin
      din_a = n[0];
      qa.push_back('{edge_no: edge_n + 6, rise: n[0]});
      tick(10);
    end
    check("alt_data", {31'd0, data_a}, 32'd0);

    // Short glitch: 3 cycles high is rejected.
    din_a = 1'b1;
    tick(3);
    check("glitch_busy_mid", {31'd0, busy_a}, 32'd1);
    din_a = 1'b0;
    tick(8);
    check("glitch_data", {31'd0, data_a}, 32'd0);
    check("glitch_busy_end", {31'd0, busy_a}, 32'd0);

    // Reset mid-qualify with cnt=2.
    din_a = 1'b1;
    tick(4);
    check("rq_busy_before", {31'd0, busy_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rq_data_in_rst", {31'd0, data_a}, 32'd0);
    check("rq_busy_in_rst", {31'd0, busy_a}, 32'd0);
    check("rq_pulses_in_rst", {30'd0, rise_a, fall_a}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    e0 = edge_n;
    qa.push_back('{edge_no: e0 + 6, rise: 1'b1});
    tick(1);
    check("rq_data_after_rel", {31'd0, data_a}, 32'd0);
    tick(7);
    check("rq_data_end", {31'd0, data_a}, 32'd1);

    // Pass-through: DEBOUNCE_CYCLES=1, fall at edge 3, busy never high.
    din_b = 1'b0;
    e0 = edge_n;
    qb.push_back('{edge_no: e0 + 3, rise: 1'b0});
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("b_busy_k%0d", k), {31'd0, busy_b}, 32'd0);
    end
    check("b_data_end", {31'd0, data_b}, 32'd0);

    tick(5);
    check("qa_drained", qa.size(), 32'd0);
    check("qb_drained", qb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_filter.md
# debounce_filter

Synchronises an asynchronous, bouncy single-bit input (push-button, external strobe, GPIO) into the `i_clk` domain. It accepts a new level only after that level has been held for a programmable number of consecutive clock cycles. It provides a clean registered level plus one-cycle rise/fall pulses. It sits at the input boundary, upstream of the codebase's edge-detection and event-handling logic, which may consume either the level or the pulses.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth; legal range ≥ 2.
- `DEBOUNCE_CYCLES`, default 1000: number of consecutive synchronised samples of a new level required before it is accepted; legal range ≥ 1.
- `RESET_VALUE`, default 0: level held by the synchroniser and by `o_data` during and after reset.
- `i_clk` input 1: single clock. All logic is on the rising edge.
- `i_rst_n` input 1: reset, asynchronous and active-low. It asserts asynchronously and is released synchronously by the upstream reset controller.
- `i_data` input 1: raw asynchronous input; it may glitch at any time.
- `o_data` output 1: debounced level, registered. Reset value is `RESET_VALUE`.
- `o_rise` output 1: one-cycle pulse on an accepted 0→1 transition, registered. Reset value is 0.
- `o_fall` output 1: one-cycle pulse on an accepted 1→0 transition, registered. Reset value is 0.
- `o_busy` output 1: high while a candidate level is being qualified. Decoded from the state register; reset value is 0.

## Operation
- **Synchroniser:** a chain of `SYNC_STAGES` flops. All stages reset to `RESET_VALUE`. The chain output is `sync`.
- **Counter:** `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`, reset value 0. It counts consecutive edges on which `sync != o_data`.
- **State `ST_STABLE`:**
  - If `sync == o_data`, remain in `ST_STABLE`.
  - If `sync != o_data` and `DEBOUNCE_CYCLES == 1`, update `o_data <= sync` at this edge, fire the matching pulse, and stay in `ST_STABLE`.
  - Otherwise set `cnt <= 1` and move to `ST_QUALIFY`.
- **State `ST_QUALIFY`:**
  - If `sync == o_data`, the candidate is a glitch: set `cnt <= 0`, go to `ST_STABLE`, and generate no pulse.
  - If `sync != o_data` and `cnt+1 == DEBOUNCE_CYCLES`, accept the level: `o_data <= sync`, `cnt <= 0`, go to `ST_STABLE`, and assert `o_rise` or `o_fall` for exactly this one cycle.
  - Otherwise increment `cnt`.
- **Level vs. candidate:** only one bit of candidate exists, the opposite of `o_data`. Any return to the current level restarts qualification from zero.
- **Pulses:**
  - `o_rise` and `o_fall` are never high simultaneously.
  - Each accepted transition produces exactly one pulse.
  - No pulse is produced without a change of `o_data`.
- **Counter range:** `cnt` never exceeds `DEBOUNCE_CYCLES-1` and never wraps.
- **Reset mid-operation:** all flops return to reset values immediately, and any qualification in progress is discarded. After release, an input differing from `RESET_VALUE` is qualified normally and then produces its pulse. Reset release itself produces no pulse.

## Timing
- **Latency:** `i_data` settles to a new level before edge 1. `o_data` and the pulse change at edge `SYNC_STAGES + DEBOUNCE_CYCLES`, counting edge 1 as the first capturing edge.
- **Pulse width:** exactly one `i_clk` cycle.
- **Back-to-back transitions:** the minimum spacing between two accepted transitions is `DEBOUNCE_CYCLES` cycles.
- **Glitch rejection:** a glitch shorter than `DEBOUNCE_CYCLES` cycles at `sync` is fully rejected.
- **`o_busy`:** rises one cycle after `sync` first differs. It falls in the cycle after acceptance or rejection.

## Structure
- **Shared package `aux_pkg`:** holds the `typedef enum logic {ST_STABLE, ST_QUALIFY} debounce_state_t`.
- **Local parameter:** the counter width is a `localparam` computed inside the module.
- **Sub-module `sync_chain`:** parameters `STAGES` and `RESET_VALUE`; ports `i_clk`, `i_rst_n`, `i_data`, `o_data`. It is reused by other CDC inputs.
- **Elaboration checks:** an assertion fails elaboration if `SYNC_STAGES < 2` or `DEBOUNCE_CYCLES < 1`.

## Test plan
All scenarios use `SYNC_STAGES=2`, `DEBOUNCE_CYCLES=4`, `RESET_VALUE=0` unless stated.
- **Clean rise:** hold `i_data=1` from edge 1 → `o_data` rises at edge 6, `o_rise` is high for one cycle, and `o_busy` is high for 3 cycles before it.
- **Bounce then settle:** toggle `i_data` 1,0,1,1,0,1 on successive cycles, then hold 1 → no `o_data` change or pulse during the bounce. The rise occurs 4 sync-samples after the final hold begins, with exactly one `o_rise`.
- **Short glitch:** a 3-cycle high pulse on `i_data` → `o_data` stays 0, no pulses, and `o_busy` returns to 0.
- **Fall and spacing:** after an accepted 1, drive `i_data=0` → `o_fall` fires once after 6 edges. Repeated alternation every 10 cycles yields alternating rise/fall pulses, never simultaneous.
- **Reset mid-qualify:** assert `i_rst_n=0` with `cnt=2`, release while `i_data=1` → `o_data=0` and no pulse immediately. `o_rise` fires at edge 6 after release.
- **Pass-through parameters:** `DEBOUNCE_CYCLES=1`, `RESET_VALUE=1` → `o_data=1` out of reset. A `i_data=0` step gives `o_fall` at edge 3, and `o_busy` is never asserted.
